// File: rtl/capture_wr_arbiter_if.sv
// capture_wr_arbiter_if: request-side and AXI4 write-channel bundle for capture_wr_arbiter.
// The master modport is the arbiter view. The slave modport is the view of the capture
// engines and the DDR interconnect together.
interface capture_wr_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 34,
  parameter int ID_WIDTH   = 6
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  // capture engine requests
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data;
  logic [NUM_PORTS*KEEP_WIDTH-1:0] req_strb;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            req_done;
  logic [NUM_PORTS-1:0]            req_err;

  // AXI4 write address channel
  logic [ID_WIDTH-1:0]   m_axi_awid;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]            m_axi_awlen;
  logic [2:0]            m_axi_awsize;
  logic [1:0]            m_axi_awburst;
  logic                  m_axi_awlock;
  logic [3:0]            m_axi_awcache;
  logic [2:0]            m_axi_awprot;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;

  // AXI4 write data channel
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [KEEP_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wlast;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;

  // AXI4 write response channel
  logic [ID_WIDTH-1:0]   m_axi_bid;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  // status
  logic                  busy;

  modport master (
    input  req_valid, req_addr, req_data, req_strb,
    output req_ready, req_done, req_err,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    output m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output busy
  );

  modport slave (
    output req_valid, req_addr, req_data, req_strb,
    input  req_ready, req_done, req_err,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
    input  m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  busy
  );
endinterface

// File: rtl/capture_wr_arbiter.sv
// capture_wr_arbiter: round-robin arbiter that shares one AXI4 write master among
// NUM_PORTS capture engines. Each engine issues single-beat, full-width writes.
// Only one write is outstanding at a time. The arbiter latches a request, issues AW and W
// together, waits for B, and then pulses done/err back to the granted port.
// Optional build macro ARB_TIMEOUT_EN adds a B-channel watchdog (TIMEOUT cycles)
// and the sticky timeout_flag output.
module capture_wr_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 34,
  parameter int ID_WIDTH   = 6,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 m_axi_aclk,
  input  logic                 m_axi_rst,
  capture_wr_arbiter_if.master bus
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                 timeout_flag
`endif
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LATCH     = 2'd1,
    S_ADDR_DATA = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [PTR_W-1:0]        r_rr_ptr;
  logic [PTR_W-1:0]        r_grant;
  logic [PTR_W-1:0]        w_sel;
  logic [PTR_W-1:0]        w_ptr_nxt;
  logic [PTR_W:0]          w_idx;
  logic                    w_found;

  logic [NUM_PORTS-1:0]    r_req_ready;
  logic [NUM_PORTS-1:0]    r_done;
  logic [NUM_PORTS-1:0]    r_err;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_bready;
  logic [ADDR_WIDTH-1:0]   r_awaddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [KEEP_WIDTH-1:0]   r_wstrb;

  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_b_hs;
  logic                    w_aw_clear;
  logic                    w_w_clear;
  logic                    w_finish;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  logic [TMO_W-1:0]        r_tmo_cnt;
  logic                    r_timeout_flag;
  logic                    w_tmo_fire;
`endif

  assign w_aw_hs    = r_awvalid & bus.m_axi_awready;
  assign w_w_hs     = r_wvalid  & bus.m_axi_wready;
  assign w_b_hs     = r_bready  & bus.m_axi_bvalid;
  // A channel counts as finished when it has already completed or completes this cycle.
  assign w_aw_clear = ~r_awvalid | bus.m_axi_awready;
  assign w_w_clear  = ~r_wvalid  | bus.m_axi_wready;
  assign w_ptr_nxt  = (r_grant == PTR_W'(NUM_PORTS - 1)) ? '0 : r_grant + 1'b1;

  // Round-robin search: first asserted request at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_W + 1)'(i);
      if (w_idx >= (PTR_W + 1)'(NUM_PORTS)) begin
        w_idx = w_idx - (PTR_W + 1)'(NUM_PORTS);
      end
      if (!w_found && bus.req_valid[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[PTR_W-1:0];
      end
    end
  end

  // Next-state logic. A B handshake completing in the same cycle beats the watchdog.
  always_comb begin
    w_state_nxt = r_state;
    w_finish    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_tmo_fire  = 1'b0;
`endif
    case (r_state)
      S_IDLE:      if (w_found) w_state_nxt = S_LATCH;
      S_LATCH:     w_state_nxt = S_ADDR_DATA;
      S_ADDR_DATA: if (w_aw_clear && w_w_clear) w_state_nxt = S_RESP;
      S_RESP: begin
        if (w_b_hs) begin
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end
      end
      default:     w_state_nxt = S_IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    if ((r_state == S_ADDR_DATA || r_state == S_RESP) && !w_finish &&
        (r_tmo_cnt == TMO_W'(TIMEOUT - 1))) begin
      w_tmo_fire  = 1'b1;
      w_state_nxt = S_IDLE;
    end
`endif
  end

  // State register.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake, grant and status registers. Pulses default low each cycle.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_rst) begin
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_req_ready <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
    end else begin
      r_req_ready <= '0;
      r_done      <= '0;
      r_err       <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_req_ready[w_sel] <= 1'b1;
            r_grant            <= w_sel;
          end
        end
        S_LATCH: begin
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
        end
        S_ADDR_DATA: begin
          if (w_aw_hs) r_awvalid <= 1'b0;
          if (w_w_hs)  r_wvalid  <= 1'b0;
          if (w_state_nxt == S_RESP) r_bready <= 1'b1;
        end
        S_RESP: begin
          if (w_b_hs) begin
            r_bready         <= 1'b0;
            r_done[r_grant]  <= 1'b1;
            r_err[r_grant]   <= bus.m_axi_bresp[1];
            r_rr_ptr         <= w_ptr_nxt;
          end
        end
        default: ;
      endcase
`ifdef ARB_TIMEOUT_EN
      if (w_tmo_fire) begin
        r_awvalid       <= 1'b0;
        r_wvalid        <= 1'b0;
        r_bready        <= 1'b0;
        r_done[r_grant] <= 1'b1;
        r_err[r_grant]  <= 1'b1;
        r_rr_ptr        <= w_ptr_nxt;
      end
`endif
    end
  end

  // Payload capture from the winning port at grant time. The payload is held until the next grant.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_rst) begin
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
    end else if (r_state == S_IDLE && w_found) begin
      r_awaddr <= bus.req_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
      r_wdata  <= bus.req_data[w_sel*DATA_WIDTH +: DATA_WIDTH];
      r_wstrb  <= bus.req_strb[w_sel*KEEP_WIDTH +: KEEP_WIDTH];
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog: counts cycles spent waiting on AW/W/B. The flag stays set until reset.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_rst) begin
      r_tmo_cnt      <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      if (w_state_nxt == S_ADDR_DATA || w_state_nxt == S_RESP) begin
        r_tmo_cnt <= (r_state == S_LATCH) ? '0 : r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end
      if (w_tmo_fire) r_timeout_flag <= 1'b1;
    end
  end

  assign timeout_flag = r_timeout_flag;
`endif

  assign bus.req_ready     = r_req_ready;
  assign bus.req_done      = r_done;
  assign bus.req_err       = r_err;

  assign bus.m_axi_awid    = ID_WIDTH'(r_grant);
  assign bus.m_axi_awaddr  = r_awaddr;
  assign bus.m_axi_awlen   = 8'd0;
  assign bus.m_axi_awsize  = 3'($clog2(KEEP_WIDTH));
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_awlock  = 1'b0;
  assign bus.m_axi_awcache = 4'd0;
  assign bus.m_axi_awprot  = 3'd0;
  assign bus.m_axi_awvalid = r_awvalid;

  assign bus.m_axi_wdata   = r_wdata;
  assign bus.m_axi_wstrb   = r_wstrb;
  assign bus.m_axi_wlast   = r_wvalid;
  assign bus.m_axi_wvalid  = r_wvalid;

  assign bus.m_axi_bready  = r_bready;
  assign bus.busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_capture_wr_arbiter.sv
// tb_capture_wr_arbiter: directed scoreboard bench for capture_wr_arbiter.
// Define ARB_TIMEOUT_EN to also exercise the B-channel watchdog (TIMEOUT = 16).
module tb_capture_wr_arbiter;
  localparam int NP  = 4;
  localparam int DW  = 512;
  localparam int AW  = 34;
  localparam int IW  = 6;
  localparam int TMO = 16;
  localparam int KW  = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  capture_wr_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) ifc ();

`ifdef ARB_TIMEOUT_EN
  logic timeout_flag;
`endif

  capture_wr_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .TIMEOUT(TMO)
  ) dut (
    .m_axi_aclk (clk),
    .m_axi_rst  (rst),
    .bus        (ifc)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout_flag (timeout_flag)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic [2:0]    port;
    logic [AW-1:0] addr;
    logic          err;
  } exp_t;

  exp_t aw_q[$];
  exp_t done_q[$];
  exp_t mon_x;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [2:0] p, input logic [AW-1:0] a);
    logic [31:0] w;
    w = a[31:0] ^ {29'h00A5A5A5, p};
    return {(DW/32){w}};
  endfunction

  function automatic logic [KW-1:0] mk_strb(input logic [2:0] p);
    return (p == 3'd3) ? {(KW/2){2'b01}} : {KW{1'b1}};
  endfunction

  // ---------------- AXI slave model ----------------
  int          aw_dly = 0;
  int          aw_cnt = 0;
  logic        b_en   = 1'b1;
  logic [1:0]  bresp_for [NP];

  always @(posedge clk) begin
    if (rst || !ifc.m_axi_awvalid || ifc.m_axi_awready) aw_cnt <= 0;
    else aw_cnt <= aw_cnt + 1;
  end
  assign ifc.m_axi_awready = ifc.m_axi_awvalid && (aw_cnt >= aw_dly);
  assign ifc.m_axi_wready  = ifc.m_axi_wvalid;

  always @(posedge clk) begin
    if (rst) begin
      ifc.m_axi_bvalid <= 1'b0;
      ifc.m_axi_bresp  <= 2'b00;
      ifc.m_axi_bid    <= '0;
    end else if (ifc.m_axi_bvalid && ifc.m_axi_bready) begin
      ifc.m_axi_bvalid <= 1'b0;
    end else if (ifc.m_axi_bready && b_en && !ifc.m_axi_bvalid) begin
      ifc.m_axi_bvalid <= 1'b1;
      ifc.m_axi_bresp  <= bresp_for[ifc.m_axi_awid[1:0]];
      ifc.m_axi_bid    <= ifc.m_axi_awid;
    end
  end

  // ---------------- requesters ----------------
  logic [AW-1:0] pend_addr [NP][8];
  int            pend_wr   [NP];
  int            pend_rd   [NP];
  logic [NP-1:0] rdy_s;

  initial begin
    ifc.req_valid = '0;
    ifc.req_addr  = '0;
    ifc.req_data  = '0;
    ifc.req_strb  = '0;
    for (int p = 0; p < NP; p++) begin
      pend_wr[p] = 0;
      pend_rd[p] = 0;
    end
    forever begin
      @(negedge clk);
      rdy_s = ifc.req_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (rdy_s[p] && ifc.req_valid[p]) pend_rd[p]++;
        if (pend_rd[p] < pend_wr[p]) begin
          ifc.req_valid[p]          = 1'b1;
          ifc.req_addr[p*AW +: AW]  = pend_addr[p][pend_rd[p] % 8];
          ifc.req_data[p*DW +: DW]  = mk_data(3'(p), pend_addr[p][pend_rd[p] % 8]);
          ifc.req_strb[p*KW +: KW]  = mk_strb(3'(p));
        end else begin
          ifc.req_valid[p] = 1'b0;
        end
      end
    end
  end

  task automatic add_req(input int p, input logic [AW-1:0] a);
    pend_addr[p][pend_wr[p] % 8] = a;
    pend_wr[p]++;
  endtask

  task automatic expect_txn(input int p, input logic [AW-1:0] a, input logic e);
    exp_t x;
    x.port = 3'(p);
    x.addr = a;
    x.err  = e;
    aw_q.push_back(x);
    done_q.push_back(x);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.m_axi_awvalid && ifc.m_axi_awready) begin
        if (aw_q.size() == 0) begin
          n_total++;
          $display("FAIL aw_unexpected: awaddr %0h awid %0h, required no write", ifc.m_axi_awaddr, ifc.m_axi_awid);
        end else begin
          mon_x = aw_q.pop_front();
          chk("awaddr", DW'(ifc.m_axi_awaddr), DW'(mon_x.addr));
          chk("awid",   DW'(ifc.m_axi_awid),   DW'(mon_x.port));
          chk("wdata",  ifc.m_axi_wdata,       mk_data(mon_x.port, mon_x.addr));
          chk("wstrb",  DW'(ifc.m_axi_wstrb),  DW'(mk_strb(mon_x.port)));
        end
      end
      if (|ifc.req_done || |ifc.req_err) begin
        if (done_q.size() == 0) begin
          n_total++;
          $display("FAIL done_unexpected: done %0h err %0h, required none", ifc.req_done, ifc.req_err);
        end else begin
          mon_x = done_q.pop_front();
          chk("done_vec", DW'(ifc.req_done), DW'(NP'(1) << mon_x.port));
          chk("err_vec",  DW'(ifc.req_err),  mon_x.err ? DW'(NP'(1) << mon_x.port) : '0);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic bit pending();
    bit r;
    r = 1'b0;
    for (int p = 0; p < NP; p++) if (pend_rd[p] != pend_wr[p]) r = 1'b1;
    return r;
  endfunction

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while ((pending() || aw_q.size() != 0 || done_q.size() != 0 || ifc.busy) && k < budget) begin
      cyc(1);
      k++;
    end
    n_total++;
    if (k < budget) n_pass++;
    else $display("FAIL %s_drain: %0d completions outstanding after %0d cycles, required 0", name, done_q.size(), budget);
  endtask

  task automatic wait_awvalid(input string name, input int budget);
    int k;
    k = 0;
    while (!ifc.m_axi_awvalid && k < budget) begin
      cyc(1);
      k++;
    end
    chk(name, DW'(ifc.m_axi_awvalid), DW'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    for (int p = 0; p < NP; p++) bresp_for[p] = 2'b00;
    rst = 1'b1;
    cyc(3);
    chk("rst_busy",    DW'(ifc.busy),          '0);
    chk("rst_awvalid", DW'(ifc.m_axi_awvalid), '0);
    chk("rst_wvalid",  DW'(ifc.m_axi_wvalid),  '0);
    chk("rst_bready",  DW'(ifc.m_axi_bready),  '0);
    chk("rst_ready",   DW'(ifc.req_ready),     '0);
    chk("rst_done",    DW'(ifc.req_done),      '0);
    chk("rst_awaddr",  DW'(ifc.m_axi_awaddr),  '0);
    chk("rst_wdata",   ifc.m_axi_wdata,        '0);
    chk("awlen",       DW'(ifc.m_axi_awlen),   '0);
    chk("awsize",      DW'(ifc.m_axi_awsize),  DW'(6));
    chk("awburst",     DW'(ifc.m_axi_awburst), DW'(1));
`ifdef ARB_TIMEOUT_EN
    chk("rst_tmo_flag", DW'(timeout_flag), '0);
`endif
    rst = 1'b0;
    cyc(1);

    // 1: single request, port 0, exact grant/issue timing
    add_req(0, 34'h1000);
    expect_txn(0, 34'h1000, 1'b0);
    cyc(1);
    cyc(1);
    chk("t1_ready_t1",   DW'(ifc.req_ready),     DW'(4'b0001));
    chk("t1_awvalid_t1", DW'(ifc.m_axi_awvalid), '0);
    chk("t1_busy",       DW'(ifc.busy),          DW'(1));
    cyc(1);
    chk("t1_awvalid_t2", DW'(ifc.m_axi_awvalid), DW'(1));
    chk("t1_wvalid_t2",  DW'(ifc.m_axi_wvalid),  DW'(1));
    chk("t1_wlast_t2",   DW'(ifc.m_axi_wlast),   DW'(1));
    chk("t1_awid",       DW'(ifc.m_axi_awid),    '0);
    wait_done("t1", 50);
    chk("t1_busy_after", DW'(ifc.busy), '0);

    // 2: all ports request continuously from a fresh reset -> 0,1,2,3,0,1,2,3
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NP; p++) begin
        add_req(p, AW'(32'h2000 + r * 32'h1000 + p * 32'h100));
        expect_txn(p, AW'(32'h2000 + r * 32'h1000 + p * 32'h100), 1'b0);
      end
    end
    wait_done("t2", 300);

    // 3: awready 5 cycles late, wready immediate
    aw_dly = 5;
    add_req(1, 34'h3_0000_0040);
    expect_txn(1, 34'h3_0000_0040, 1'b0);
    wait_awvalid("t3_awvalid_rise", 20);
    cyc(1);
    chk("t3_wvalid_first", DW'(ifc.m_axi_wvalid),  '0);
    chk("t3_awvalid_held", DW'(ifc.m_axi_awvalid), DW'(1));
    chk("t3_no_resp_yet",  DW'(ifc.m_axi_bready),  '0);
    k = 0;
    while (ifc.m_axi_awvalid && k < 20) begin
      cyc(1);
      k++;
    end
    chk("t3_aw_wait_cycles", DW'(k), DW'(5));
    chk("t3_bready_after_aw", DW'(ifc.m_axi_bready), DW'(1));
    aw_dly = 0;
    wait_done("t3", 50);

    // 4: SLVERR on port 2; rr pointer then starts at port 3
    bresp_for[2] = 2'b10;
    add_req(2, 34'h4200);
    add_req(0, 34'h4000);
    add_req(3, 34'h4300);
    expect_txn(2, 34'h4200, 1'b1);
    expect_txn(3, 34'h4300, 1'b0);
    expect_txn(0, 34'h4000, 1'b0);
    wait_done("t4", 150);
    bresp_for[2] = 2'b00;

    // 5: reset while in ADDR_DATA; no completion, pointer back to port 0
    aw_dly = 100;
    add_req(1, 34'h5100);
    wait_awvalid("t5_awvalid_rise", 20);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("t5_awvalid", DW'(ifc.m_axi_awvalid), '0);
    chk("t5_wvalid",  DW'(ifc.m_axi_wvalid),  '0);
    chk("t5_bready",  DW'(ifc.m_axi_bready),  '0);
    chk("t5_busy",    DW'(ifc.busy),          '0);
    chk("t5_done",    DW'(ifc.req_done),      '0);
    rst = 1'b0;
    aw_dly = 0;
    cyc(1);
    add_req(1, 34'h5110);
    add_req(0, 34'h5000);
    expect_txn(0, 34'h5000, 1'b0);
    expect_txn(1, 34'h5110, 1'b0);
    wait_done("t5", 100);

`ifdef ARB_TIMEOUT_EN
    // 6: B never returns -> watchdog completes with error after TIMEOUT cycles
    b_en = 1'b0;
    add_req(2, 34'h6200);
    expect_txn(2, 34'h6200, 1'b1);
    wait_awvalid("t6_awvalid_rise", 20);
    k = 0;
    while (!(|ifc.req_done) && k < 40) begin
      cyc(1);
      k++;
    end
    chk("t6_tmo_latency", DW'(k), DW'(TMO));
    chk("t6_tmo_flag",    DW'(timeout_flag), DW'(1));
    chk("t6_bready_drop", DW'(ifc.m_axi_bready), '0);
    b_en = 1'b1;
    wait_done("t6", 50);
    add_req(3, 34'h6300);
    expect_txn(3, 34'h6300, 1'b0);
    wait_done("t6b", 50);
    chk("t6_tmo_sticky", DW'(timeout_flag), DW'(1));
`endif

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end
endmodule
